// File: rtl/johnson_decoder_if.sv
// johnson_decoder_if: sample and decoded-result bundle for johnson_decoder (oOneHot present only with JOHNSON_DECODER_ONEHOT_EN)
interface johnson_decoder_if #(parameter int N = 4);
  localparam int W = $clog2(2 * N);
  logic [N-1:0] iJohnson;
  logic         iValid;
  logic [W-1:0] oIndex;
  logic         oValid;
  logic         oLegal;
  logic         oLocked;
  logic         oCodeErr;
  logic         oSeqErr;
  logic [7:0]   oErrCount;
`ifdef JOHNSON_DECODER_ONEHOT_EN
  logic [2*N-1:0] oOneHot;
`endif
  modport master (
    output iJohnson, iValid,
`ifdef JOHNSON_DECODER_ONEHOT_EN
    input oOneHot,
`endif
    input oIndex, oValid, oLegal, oLocked, oCodeErr, oSeqErr, oErrCount
  );
  modport slave (
    input iJohnson, iValid,
`ifdef JOHNSON_DECODER_ONEHOT_EN
    output oOneHot,
`endif
    output oIndex, oValid, oLegal, oLocked, oCodeErr, oSeqErr, oErrCount
  );
endinterface

// File: rtl/johnson_decoder.sv
// johnson_decoder: Johnson code decoder with lock tracking and error counting; JOHNSON_DECODER_ONEHOT_EN adds oOneHot
module johnson_decoder #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3
) (
  input  logic iClk,
  input  logic iRst_n,
  johnson_decoder_if.slave bus
);
  localparam int W = $clog2(2 * N);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t       state, state_n;
  logic [3:0]   run, run_n;
  logic [W-1:0] prev, prev_n, idx, succ, idx_q, idx_n;
  logic         prev_vld, prev_vld_n, hit, in_seq;
  logic         legal_q, legal_n, valid_q, valid_n, cerr_q, cerr_n, serr_q, serr_n;
  logic [7:0]   cnt, cnt_n;
  function automatic logic [N-1:0] code_of(input int k);
    logic [N-1:0] m;
    m = N'((32'd1 << (k <= N ? k : k - N)) - 32'd1);
    return k <= N ? m : ~m;
  endfunction
  // Match the sample against every legal code to find its position
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < 2 * N; k++)
      if (bus.iJohnson == code_of(k)) begin
        hit = 1'b1;
        idx = W'(k);
      end
  end
  assign succ   = (prev == W'(2 * N - 1)) ? '0 : prev + 1'b1;
  assign in_seq = prev_vld && idx == succ;
  // Lock FSM, run counter, error counter and next output values
  always_comb begin
    state_n    = state;
    run_n      = run;
    prev_n     = prev;
    prev_vld_n = prev_vld;
    idx_n      = idx_q;
    legal_n    = legal_q;
    cnt_n      = cnt;
    valid_n    = 1'b0;
    cerr_n     = 1'b0;
    serr_n     = 1'b0;
    if (bus.iValid) begin
      valid_n    = 1'b1;
      legal_n    = hit;
      idx_n      = hit ? idx : '0;
      prev_n     = idx;
      prev_vld_n = hit;
      if (!hit) begin
        cerr_n  = 1'b1;
        state_n = HUNT;
        run_n   = '0;
      end else if (state == LOCKED) begin
        serr_n  = !in_seq;
        state_n = in_seq ? LOCKED : HUNT;
        run_n   = in_seq ? run : 4'd1;
      end else begin
        run_n   = in_seq ? run + 4'd1 : 4'd1;
        state_n = (run_n >= 4'(LOCK_CNT)) ? LOCKED : HUNT;
      end
      cnt_n = ((cerr_n || serr_n) && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
    end
  end
  // State and output registers, cleared asynchronously
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state    <= HUNT;
      run      <= '0;
      prev     <= '0;
      prev_vld <= 1'b0;
      idx_q    <= '0;
      legal_q  <= 1'b0;
      valid_q  <= 1'b0;
      cerr_q   <= 1'b0;
      serr_q   <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      run      <= run_n;
      prev     <= prev_n;
      prev_vld <= prev_vld_n;
      idx_q    <= idx_n;
      legal_q  <= legal_n;
      valid_q  <= valid_n;
      cerr_q   <= cerr_n;
      serr_q   <= serr_n;
      cnt      <= cnt_n;
    end
  end
`ifdef JOHNSON_DECODER_ONEHOT_EN
  logic [2*N-1:0] onehot_q;
  // One-hot view of the decoded index, registered with it
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) onehot_q <= '0;
    else         onehot_q <= legal_n ? ((2 * N)'(1) << idx_n) : '0;
  end
  assign bus.oOneHot = onehot_q;
`endif
  assign bus.oIndex    = idx_q;
  assign bus.oValid    = valid_q;
  assign bus.oLegal    = legal_q;
  assign bus.oLocked   = state == LOCKED;
  assign bus.oCodeErr  = cerr_q;
  assign bus.oSeqErr   = serr_q;
  assign bus.oErrCount = cnt;
endmodule
